// File: rtl/pe_wq_pkg.sv
// Shared types and arithmetic helpers for the weight-stationary PE (package pe_pkg).
// Helpers work on a 64-bit signed accumulator, so DATA_W is limited to 32.
package pe_pkg;

  typedef enum logic {
    PE_MODE_MAC  = 1'b0,
    PE_MODE_PASS = 1'b1
  } pe_mode_e;

  localparam int PE_DATA_W_DEF   = 16;
  localparam int PE_FRAC_W_DEF   = 8;
  localparam int PE_WQ_DEPTH_DEF = 2;

  // Round half toward +inf, then drop frac_w fraction bits.
  function automatic logic signed [63:0] pe_round_shift(input logic signed [63:0] val,
                                                        input int unsigned        frac_w);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac_w - 32'd1);
    return (val + half) >>> frac_w;
  endfunction

  function automatic logic signed [63:0] pe_saturate(input logic signed [63:0] val,
                                                     input int unsigned        width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (val > hi) begin
      return hi;
    end else if (val < lo) begin
      return lo;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/pe_wq_if.sv
// PE port bundle: slave = the PE itself, master = whatever drives it (west/north neighbour or bench).
interface pe_wq_if
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W_DEF,
  parameter int WQ_DEPTH = PE_WQ_DEPTH_DEF
);
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);

  logic              pe_enabled;
  logic              pe_mode;
  logic              pe_valid_in;
  logic [DATA_W-1:0] pe_input_in;
  logic [DATA_W-1:0] pe_psum_in;
  logic              pe_accept_w_in;
  logic [DATA_W-1:0] pe_weight_in;
  logic              pe_switch_in;
  logic              pe_valid_out;
  logic [DATA_W-1:0] pe_input_out;
  logic [DATA_W-1:0] pe_psum_out;
  logic              pe_accept_w_out;
  logic [DATA_W-1:0] pe_weight_out;
  logic              pe_switch_out;
  logic [CNT_W-1:0]  pe_wq_count;
  logic              pe_w_ovf;

  modport slave (
    input  pe_enabled, pe_mode, pe_valid_in, pe_input_in, pe_psum_in,
           pe_accept_w_in, pe_weight_in, pe_switch_in,
    output pe_valid_out, pe_input_out, pe_psum_out, pe_accept_w_out,
           pe_weight_out, pe_switch_out, pe_wq_count, pe_w_ovf
  );

  modport master (
    output pe_enabled, pe_mode, pe_valid_in, pe_input_in, pe_psum_in,
           pe_accept_w_in, pe_weight_in, pe_switch_in,
    input  pe_valid_out, pe_input_out, pe_psum_out, pe_accept_w_out,
           pe_weight_out, pe_switch_out, pe_wq_count, pe_w_ovf
  );

endinterface

// File: rtl/pe_weight_queue.sv
// Pending-weight FIFO: head always at entry 0, pop shifts down, push while full overwrites the tail.
module pe_weight_queue
  import pe_pkg::*;
#(
  parameter  int DATA_W   = PE_DATA_W_DEF,
  parameter  int WQ_DEPTH = PE_WQ_DEPTH_DEF,
  localparam int CNT_W    = $clog2(WQ_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);
  localparam int IDX_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;

  logic [DATA_W-1:0] entries_q [WQ_DEPTH];
  logic [DATA_W-1:0] entries_d [WQ_DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              do_pop_s;
  logic              full_s;
  logic [IDX_W-1:0]  wr_idx_s;

  // Next-state for entries, occupancy and overflow flag.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
    full_s    = (count_q == CNT_W'(WQ_DEPTH));
    wr_idx_s  = IDX_W'(count_q);
    if (do_pop_s) begin
      for (int i = 0; i < WQ_DEPTH - 1; i++) begin
        entries_d[IDX_W'(i)] = entries_q[IDX_W'(i + 1)];
      end
      if (push) begin
        // Head leaves and the new weight lands in the slot just vacated at the tail.
        wr_idx_s            = IDX_W'(count_q - CNT_W'(1));
        entries_d[wr_idx_s] = data;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end else if (push) begin
      if (full_s) begin
        entries_d[IDX_W'(WQ_DEPTH - 1)] = data;
        ovf_d                           = 1'b1;
      end else begin
        entries_d[wr_idx_s] = data;
        count_d             = count_q + CNT_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entries_q <= '{default: {DATA_W{1'b0}}};
      count_q   <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  assign head  = entries_q[0];
  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/pe_wq.sv
// Weight-stationary PE with pending-weight queue, psum bypass and round-half-up rescale.
// Define PE_SATURATE_EN to clamp the rescaled product and the sum instead of wrapping.
module pe_wq
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W_DEF,
  parameter int FRAC_W   = PE_FRAC_W_DEF,
  parameter int WQ_DEPTH = PE_WQ_DEPTH_DEF
) (
  input logic       clk,
  input logic       rst,
  pe_wq_if.slave    bus
);
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);

  logic                       q_push_s;
  logic                       q_pop_s;
  logic [DATA_W-1:0]          head_s;
  logic [CNT_W-1:0]           count_s;
  logic                       ovf_s;
  pe_mode_e                   mode_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [63:0]         rescaled_s;
  logic signed [63:0]         psum_ext_s;
  logic [DATA_W-1:0]          mac_s;

  logic [DATA_W-1:0] w_active_q, w_active_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] input_q, input_d;
  logic [DATA_W-1:0] psum_q, psum_d;
  logic              accept_q, accept_d;
  logic [DATA_W-1:0] weight_q, weight_d;
  logic              switch_q, switch_d;

  assign q_push_s = bus.pe_enabled & bus.pe_accept_w_in;
  assign q_pop_s  = bus.pe_enabled & bus.pe_switch_in;

  pe_weight_queue #(
    .DATA_W   (DATA_W),
    .WQ_DEPTH (WQ_DEPTH)
  ) u_wq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push_s),
    .pop   (q_pop_s),
    .data  (bus.pe_weight_in),
    .head  (head_s),
    .count (count_s),
    .ovf   (ovf_s)
  );

  // MAC datapath; always uses the pre-switch active weight.
  always_comb begin
    mode_s     = pe_mode_e'(bus.pe_mode);
    prod_s     = $signed(bus.pe_input_in) * $signed(w_active_q);
    rescaled_s = pe_round_shift(64'(prod_s), FRAC_W);
    psum_ext_s = 64'($signed(bus.pe_psum_in));
`ifdef PE_SATURATE_EN
    rescaled_s = pe_saturate(rescaled_s, DATA_W);
    mac_s      = DATA_W'(pe_saturate(rescaled_s + psum_ext_s, DATA_W));
`else
    mac_s      = DATA_W'(rescaled_s + psum_ext_s);
`endif
  end

  // Next-state for forwarding registers and active weight.
  always_comb begin
    w_active_d = w_active_q;
    valid_d    = valid_q;
    input_d    = input_q;
    psum_d     = psum_q;
    accept_d   = accept_q;
    weight_d   = weight_q;
    switch_d   = switch_q;
    if (bus.pe_enabled) begin
      valid_d  = bus.pe_valid_in;
      accept_d = bus.pe_accept_w_in;
      switch_d = bus.pe_switch_in;
      weight_d = bus.pe_accept_w_in ? bus.pe_weight_in : {DATA_W{1'b0}};
      if (bus.pe_switch_in && (count_s != {CNT_W{1'b0}})) begin
        w_active_d = head_s;
      end else begin
        w_active_d = w_active_q;
      end
      if (bus.pe_valid_in) begin
        input_d = bus.pe_input_in;
        case (mode_s)
          PE_MODE_MAC:  psum_d = mac_s;
          PE_MODE_PASS: psum_d = bus.pe_psum_in;
          default:      psum_d = {DATA_W{1'b0}};
        endcase
      end else begin
        input_d = input_q;
        psum_d  = {DATA_W{1'b0}};
      end
    end else begin
      // Disabled: only the strobes drop; data registers hold.
      valid_d  = 1'b0;
      accept_d = 1'b0;
      switch_d = 1'b0;
    end
  end

  // Output and active-weight registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_active_q <= {DATA_W{1'b0}};
      valid_q    <= 1'b0;
      input_q    <= {DATA_W{1'b0}};
      psum_q     <= {DATA_W{1'b0}};
      accept_q   <= 1'b0;
      weight_q   <= {DATA_W{1'b0}};
      switch_q   <= 1'b0;
    end else begin
      w_active_q <= w_active_d;
      valid_q    <= valid_d;
      input_q    <= input_d;
      psum_q     <= psum_d;
      accept_q   <= accept_d;
      weight_q   <= weight_d;
      switch_q   <= switch_d;
    end
  end

  assign bus.pe_valid_out    = valid_q;
  assign bus.pe_input_out    = input_q;
  assign bus.pe_psum_out     = psum_q;
  assign bus.pe_accept_w_out = accept_q;
  assign bus.pe_weight_out   = weight_q;
  assign bus.pe_switch_out   = switch_q;
  assign bus.pe_wq_count     = count_s;
  assign bus.pe_w_ovf        = ovf_s;

endmodule
